// File: rtl/seg_scan_ctrl.sv
// Scan controller for a 4-digit common-anode 7-segment display, one digit per slot with a blank gap.
// Latency: outputs registered; first digit lit BLANK_CYCLES+1 edges after enable; new value shown next frame.
// Backpressure: load_ready = pending buffer empty; pending drains only at a frame boundary or while idle.
module seg_scan_ctrl #(
  parameter int DIV_BITS     = 14,
  parameter int BLANK_CYCLES = 64
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        enable,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] load_value,
  input  logic [3:0]  load_dots,
  output logic [7:0]  seg,
  output logic [3:0]  digit_en,
  output logic        frame_done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_SHOW  = 2'd2;

  localparam logic [DIV_BITS-1:0] BLANK_LAST = DIV_BITS'(BLANK_CYCLES - 1);
  localparam logic [DIV_BITS-1:0] SLOT_LAST  = {DIV_BITS{1'b1}};

  logic [1:0]          state_q, state_d;
  logic [DIV_BITS-1:0] cnt_q, cnt_d;
  logic [1:0]          idx_q, idx_d;
  logic                pend_full_q, pend_full_d;
  logic [15:0]         pend_value_q, pend_value_d;
  logic [3:0]          pend_dots_q, pend_dots_d;
  logic [15:0]         act_value_q, act_value_d;
  logic [3:0]          act_dots_q, act_dots_d;
  logic [7:0]          seg_q, seg_d;
  logic [3:0]          digit_en_q, digit_en_d;
  logic                frame_done_q, frame_done_d;
  logic                boundary;
  logic                copy_en;
  logic                load_fire;
  logic [3:0]          nib_d;

  // Active-low gfedcba glyphs for hex digits.
  function automatic logic [6:0] font(input logic [3:0] n);
    case (n)
      4'h0:    font = 7'b1000000;
      4'h1:    font = 7'b1111001;
      4'h2:    font = 7'b0100100;
      4'h3:    font = 7'b0110000;
      4'h4:    font = 7'b0011001;
      4'h5:    font = 7'b0010010;
      4'h6:    font = 7'b0000010;
      4'h7:    font = 7'b1111000;
      4'h8:    font = 7'b0000000;
      4'h9:    font = 7'b0010000;
      4'hA:    font = 7'b0001000;
      4'hB:    font = 7'b0000011;
      4'hC:    font = 7'b1000110;
      4'hD:    font = 7'b0100001;
      4'hE:    font = 7'b0000110;
      default: font = 7'b0001110;
    endcase
  endfunction

  // Scan sequencing: slot counter, digit index and state; flags the entry into digit-0 blank.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    frame_done_d = 1'b0;
    boundary     = 1'b0;
    if (!enable) begin
      // Abandon whatever frame is in progress; no frame_done.
      state_d = ST_IDLE;
      cnt_d   = '0;
      idx_d   = 2'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d  = ST_BLANK;
          cnt_d    = '0;
          idx_d    = 2'd0;
          boundary = 1'b1;
        end
        ST_BLANK: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == BLANK_LAST) state_d = ST_SHOW;
        end
        ST_SHOW: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == SLOT_LAST) begin
            state_d = ST_BLANK;
            idx_d   = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              frame_done_d = 1'b1;
              boundary     = 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          idx_d   = 2'd0;
        end
      endcase
    end
  end

  // Pending/active buffering: copying only at frame boundaries keeps a frame tear-free.
  always_comb begin
    load_fire    = load_valid && !pend_full_q;
    copy_en      = pend_full_q && ((state_q == ST_IDLE) || boundary);
    act_value_d  = copy_en ? pend_value_q : act_value_q;
    act_dots_d   = copy_en ? pend_dots_q  : act_dots_q;
    pend_value_d = load_fire ? load_value : pend_value_q;
    pend_dots_d  = load_fire ? load_dots  : pend_dots_q;
    if (load_fire)    pend_full_d = 1'b1;
    else if (copy_en) pend_full_d = 1'b0;
    else              pend_full_d = pend_full_q;
  end

  // Output decode from next-state values so the pins are registered alongside the state.
  always_comb begin
    case (idx_d)
      2'd0:    nib_d = act_value_d[15:12];
      2'd1:    nib_d = act_value_d[11:8];
      2'd2:    nib_d = act_value_d[7:4];
      default: nib_d = act_value_d[3:0];
    endcase
    seg_d      = 8'hFF;
    digit_en_d = 4'b0000;
    if (state_d == ST_SHOW) begin
      digit_en_d = 4'b0001 << idx_d;
      seg_d      = {~act_dots_d[idx_d], font(nib_d)};
    end
  end

  // State and output registers; reset darkens the display and drops any pending value.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      pend_full_q  <= 1'b0;
      pend_value_q <= 16'h0000;
      pend_dots_q  <= 4'h0;
      act_value_q  <= 16'h0000;
      act_dots_q   <= 4'h0;
      seg_q        <= 8'hFF;
      digit_en_q   <= 4'b0000;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pend_full_q  <= pend_full_d;
      pend_value_q <= pend_value_d;
      pend_dots_q  <= pend_dots_d;
      act_value_q  <= act_value_d;
      act_dots_q   <= act_dots_d;
      seg_q        <= seg_d;
      digit_en_q   <= digit_en_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign load_ready = ~pend_full_q;
  assign seg        = seg_q;
  assign digit_en   = digit_en_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with DIV_BITS=4, BLANK_CYCLES=2 (16-cycle slots, 64-cycle frames).
// Expected scan pattern derived from the cycle index since enable rose from idle.
// Per-digit segment bytes are hand-computed from the font table.
module tb_seg_scan_ctrl;

  logic        CLK;
  logic        RST_N;
  logic        enable;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_value;
  logic [3:0]  load_dots;
  logic [7:0]  seg;
  logic [3:0]  digit_en;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  seg_scan_ctrl #(.DIV_BITS(4), .BLANK_CYCLES(2)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .enable     (enable),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_value (load_value),
    .load_dots  (load_dots),
    .seg        (seg),
    .digit_en   (digit_en),
    .frame_done (frame_done)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    enable     = 1'b0;
    load_valid = 1'b0;
    RST_N      = 1'b0;
    tick();
    tick();
    RST_N = 1'b1;
    tick();
  endtask

  // t counts edges since enable rose from idle; segs = {d0,d1,d2,d3} lit bytes.
  task automatic scan_check(input int t_start, input int t_end, input logic [31:0] segs);
    for (int t = t_start; t <= t_end; t++) begin
      int         pos;
      int         slot;
      int         c;
      logic [3:0] e_de;
      logic [7:0] e_seg;
      logic       e_fd;
      tick();
      pos  = (t - 1) % 64;
      slot = pos / 16;
      c    = pos % 16;
      e_de  = (c < 2) ? 4'b0000 : (4'b0001 << slot);
      e_seg = (c < 2) ? 8'hFF : segs[8*(3-slot) +: 8];
      e_fd  = (t > 1) && (pos == 0);
      chk($sformatf("t%0d_digit_en", t), {28'd0, digit_en}, {28'd0, e_de});
      chk($sformatf("t%0d_seg", t), {24'd0, seg}, {24'd0, e_seg});
      chk($sformatf("t%0d_frame_done", t), {31'd0, frame_done}, {31'd0, e_fd});
    end
  endtask

  initial begin
    RST_N      = 1'b1;
    enable     = 1'b0;
    load_valid = 1'b0;
    load_value = 16'h0000;
    load_dots  = 4'h0;
    #2;
    RST_N = 1'b0;
    #3;
    // Reset state
    chk("rst_seg", {24'd0, seg}, 32'h0000_00FF);
    chk("rst_digit_en", {28'd0, digit_en}, 32'd0);
    chk("rst_load_ready", {31'd0, load_ready}, 32'd1);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    tick();
    RST_N = 1'b1;
    tick();

    // Scenario 1: default value 0000, two full frames
    enable = 1'b1;
    scan_check(1, 130, 32'hC0C0_C0C0);

    // Scenario 2: load 1A3F / dots 0101 while idle
    do_reset();
    load_value = 16'h1A3F;
    load_dots  = 4'b0101;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    chk("idle_load_ready_low", {31'd0, load_ready}, 32'd0);
    tick();
    chk("idle_copy_ready_high", {31'd0, load_ready}, 32'd1);
    enable = 1'b1;
    scan_check(1, 70, 32'h7988_308E);

    // Scenario 3: mid-frame load of 1234
    load_value = 16'h1234;
    load_dots  = 4'b0000;
    load_valid = 1'b1;
    scan_check(71, 71, 32'h7988_308E);
    chk("midframe_ready_low", {31'd0, load_ready}, 32'd0);

    // Scenario 4: second offer while pending is full must be ignored
    load_value = 16'h5678;
    load_dots  = 4'b1111;
    scan_check(72, 75, 32'h7988_308E);
    load_valid = 1'b0;
    chk("full_ready_low", {31'd0, load_ready}, 32'd0);
    scan_check(76, 128, 32'h7988_308E);
    chk("frame_end_ready_low", {31'd0, load_ready}, 32'd0);
    scan_check(129, 129, 32'hF9A4_B099);
    chk("boundary_ready_high", {31'd0, load_ready}, 32'd1);
    scan_check(130, 192, 32'hF9A4_B099);

    // Scenario 5: drop enable during digit 2 SHOW
    scan_check(193, 229, 32'hF9A4_B099);
    chk("pre_drop_digit2", {28'd0, digit_en}, 32'h0000_0004);
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("drop%0d_seg", i), {24'd0, seg}, 32'h0000_00FF);
      chk($sformatf("drop%0d_digit_en", i), {28'd0, digit_en}, 32'd0);
      chk($sformatf("drop%0d_frame_done", i), {31'd0, frame_done}, 32'd0);
    end
    enable = 1'b1;
    scan_check(1, 20, 32'hF9A4_B099);

    // Scenario 6: async reset mid-SHOW with a pending value
    load_value = 16'hABCD;
    load_dots  = 4'b1111;
    load_valid = 1'b1;
    scan_check(21, 21, 32'hF9A4_B099);
    load_valid = 1'b0;
    chk("pre_rst_ready_low", {31'd0, load_ready}, 32'd0);
    chk("pre_rst_lit", {28'd0, digit_en}, 32'h0000_0002);
    #2;
    RST_N = 1'b0;
    #1;
    chk("async_rst_seg", {24'd0, seg}, 32'h0000_00FF);
    chk("async_rst_digit_en", {28'd0, digit_en}, 32'd0);
    chk("async_rst_load_ready", {31'd0, load_ready}, 32'd1);
    chk("async_rst_frame_done", {31'd0, frame_done}, 32'd0);
    enable = 1'b0;
    tick();
    RST_N = 1'b1;
    tick();
    chk("post_rst_ready", {31'd0, load_ready}, 32'd1);
    enable = 1'b1;
    scan_check(1, 20, 32'hC0C0_C0C0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
